// File: rtl/dual_port_bram_be_if.sv
// dual_port_bram_be_if: one BRAM access port (request in, registered read data and valid out)
interface dual_port_bram_be_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
);
  logic                    en;
  logic [DATA_WIDTH/8-1:0] we;
  logic [ADDR_WIDTH-1:0]   addr;
  logic [DATA_WIDTH-1:0]   din;
  logic [DATA_WIDTH-1:0]   dout;
  logic                    valid;
  modport master(output en, we, addr, din, input dout, valid);
  modport slave(input en, we, addr, din, output dout, valid);
endinterface

// File: rtl/dual_port_bram_be.sv
// dual_port_bram_be: true dual-port byte-enable RAM with clear sweep, collision flag and optional output register
module dual_port_bram_be #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int DEPTH      = 1024,
  parameter int READ_MODE  = 0,
  parameter int OUT_REG    = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 init_req,
  output logic                 ready,
  output logic                 collision,
  dual_port_bram_be_if.slave   port_a,
  dual_port_bram_be_if.slave   port_b
);
  localparam int NB = DATA_WIDTH / 8;
  localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEP = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [IW-1:0] LAST = IW'(DEPTH - 1);
  typedef enum logic {CLEAR, READY} state_t;
  state_t                  state_q, state_d;
  logic [IW-1:0]           cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];
  logic                    en [2];
  logic [NB-1:0]           we [2];
  logic [ADDR_WIDTH-1:0]   addr [2];
  logic [DATA_WIDTH-1:0]   din [2];
  logic                    acc [2];
  logic                    inr [2];
  logic                    wr [2];
  logic [DATA_WIDTH-1:0]   rdata [2];
  logic [DATA_WIDTH-1:0]   s1_q [2];
  logic [DATA_WIDTH-1:0]   s1_d [2];
  logic                    s1v_q [2];
  logic                    s1v_d [2];
  logic [DATA_WIDTH-1:0]   dout_q [2];
  logic [DATA_WIDTH-1:0]   dout_d [2];
  logic                    valid_q [2];
  logic                    valid_d [2];
  logic                    coll_q, coll_d;
  logic                    go;
  assign en[0]   = port_a.en;
  assign en[1]   = port_b.en;
  assign we[0]   = port_a.we;
  assign we[1]   = port_b.we;
  assign addr[0] = port_a.addr;
  assign addr[1] = port_b.addr;
  assign din[0]  = port_a.din;
  assign din[1]  = port_b.din;
  assign ready        = state_q == READY;
  assign go           = ready && !init_req;
  assign collision    = coll_q;
  assign port_a.dout  = dout_q[0];
  assign port_a.valid = valid_q[0];
  assign port_b.dout  = dout_q[1];
  assign port_b.valid = valid_q[1];
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == CLEAR) begin
      state_d = cnt_q == LAST ? READY : CLEAR;
      cnt_d   = cnt_q == LAST ? '0 : cnt_q + 1'b1;
    end else if (init_req) begin
      state_d = CLEAR;
    end
  end
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      acc[i]   = go && en[i];
      inr[i]   = {1'b0, addr[i]} < DEP;
      wr[i]    = acc[i] && inr[i] && |we[i];
      rdata[i] = inr[i] ? mem[addr[i][IW-1:0]] : '0;
      for (int j = 0; j < NB; j++)
        if (READ_MODE == 1 && inr[i] && we[i][j]) rdata[i][8*j +: 8] = din[i][8*j +: 8];
      s1_d[i]    = acc[i] ? rdata[i] : s1_q[i];
      s1v_d[i]   = acc[i];
      dout_d[i]  = OUT_REG == 1 ? (s1v_q[i] ? s1_q[i] : dout_q[i]) : s1_d[i];
      valid_d[i] = OUT_REG == 1 ? s1v_q[i] : acc[i];
    end
    coll_d = wr[0] && wr[1] && addr[0] == addr[1];
  end
  always_ff @(posedge clk) begin
    if (state_q == CLEAR) begin
      mem[cnt_q] <= '0;
    end else begin
      for (int i = 1; i >= 0; i--)
        if (wr[i])
          for (int j = 0; j < NB; j++)
            if (we[i][j]) mem[addr[i][IW-1:0]][8*j +: 8] <= din[i][8*j +: 8];
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
      coll_q  <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        s1_q[i]    <= '0;
        s1v_q[i]   <= 1'b0;
        dout_q[i]  <= '0;
        valid_q[i] <= 1'b0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      coll_q  <= coll_d;
      for (int i = 0; i < 2; i++) begin
        s1_q[i]    <= s1_d[i];
        s1v_q[i]   <= s1v_d[i];
        dout_q[i]  <= dout_d[i];
        valid_q[i] <= valid_d[i];
      end
    end
  end
endmodule
